// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg: shared constants for the LCD command sequencer.
//   - FSM state codes (3-bit, legacy-compatible localparams)
//   - power-on init command ROM and its depth
//   - clear/home command codes and the long-execution-wait predicate
//   - small elaboration helper (max of two unsigned ints)
package lcd_seq_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_PWRUP = 3'd0;
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd1;
  localparam logic [STATE_W-1:0] ST_SETUP = 3'd2;
  localparam logic [STATE_W-1:0] ST_EHIGH = 3'd3;
  localparam logic [STATE_W-1:0] ST_HOLD  = 3'd4;
  localparam logic [STATE_W-1:0] ST_WAIT  = 3'd5;

  localparam int unsigned INIT_DEPTH = 6;
  localparam int unsigned INIT_IDX_W = $clog2(INIT_DEPTH);

  // 8-bit/2-line function set (x3), display on, clear, entry mode increment
  localparam logic [7:0] INIT_ROM [INIT_DEPTH] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Clear (0x01) and home (0x02/0x03, bit 0 is don't-care) need the long wait;
  // 0x00 is lumped in with them so the rule stays "command <= 0x03".
  function automatic logic is_long_wait(input logic rs, input logic [7:0] data);
    return !rs && ((data == 8'h00) || (data == CMD_CLEAR) ||
                   (data == CMD_HOME) || (data == 8'h03));
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_seq_timer.sv
// lcd_seq_timer: loadable saturating down-counter used for every phase delay.
//   clk, rst_n   : clock, async active-low reset (counter returns to RST_VAL)
//   load         : load load_val this cycle (takes priority over counting)
//   load_val     : W-bit start value (phase length minus one)
//   done_c       : combinational, high while the count is zero
module lcd_seq_timer #(
  parameter int unsigned     W       = 8,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] cnt_q, cnt_d;

  // Count down to zero and park there until the next load
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: drives HD44780-class 8-bit LCD write cycles
// (setup / E pulse / hold / execution wait) for one {RS, byte} request at a time.
// Optional macro LCD_INIT_SEQ_EN: run power-up wait plus the init command ROM
// after reset before accepting requests; otherwise ready right after reset.
// Ports:
//   ACLK, ARESETN           : clock, async active-low reset
//   req_valid/req_ready     : request handshake (transfer when both high)
//   req_rs, req_data        : register select (0 cmd, 1 data) and byte
//   busy                    : bus cycle, wait or init in progress
//   init_done               : sticky init-complete flag
//   lcd_rs, lcd_rw, lcd_e, lcd_db : LCD pins (rw tied low, write only)
module lcd_cmd_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int unsigned T_PWRUP_CYC = 1500000,
  parameter int unsigned T_SETUP_CYC = 4,
  parameter int unsigned T_EPW_CYC   = 25,
  parameter int unsigned T_HOLD_CYC  = 4,
  parameter int unsigned T_CMD_CYC   = 4000,
  parameter int unsigned T_CLR_CYC   = 164000
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db
);

  localparam int unsigned T_MAX = max_u(max_u(max_u(T_PWRUP_CYC, T_SETUP_CYC),
                                              max_u(T_EPW_CYC, T_HOLD_CYC)),
                                        max_u(T_CMD_CYC, T_CLR_CYC));
  localparam int unsigned CNT_W = $clog2(T_MAX + 1);

  // Zero-length phases would break the load-(N-1) counting scheme
  if (T_PWRUP_CYC < 1 || T_SETUP_CYC < 1 || T_EPW_CYC < 1 ||
      T_HOLD_CYC < 1 || T_CMD_CYC < 1 || T_CLR_CYC < 1) begin : g_param_chk
    $error("lcd_cmd_sequencer: every timing parameter must be >= 1");
  end

`ifdef LCD_INIT_SEQ_EN
  localparam logic [STATE_W-1:0] ST_RESET = ST_PWRUP;
  localparam logic [CNT_W-1:0]   CNT_RST  = CNT_W'(T_PWRUP_CYC - 1);
`else
  localparam logic [STATE_W-1:0] ST_RESET = ST_IDLE;
  localparam logic [CNT_W-1:0]   CNT_RST  = '0;
`endif

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EPW   = CNT_W'(T_EPW_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR_CYC - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic               busy_q, busy_d;
  logic               init_done_q, init_done_d;
  logic               lcd_rs_q, lcd_rs_d;
  logic               lcd_e_q, lcd_e_d;
  logic [7:0]         lcd_db_q, lcd_db_d;
  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_done;
`ifdef LCD_INIT_SEQ_EN
  logic [INIT_IDX_W-1:0] rom_idx_q, rom_idx_d;
  logic [INIT_IDX_W-1:0] rom_idx_nxt;
  assign rom_idx_nxt = rom_idx_q + INIT_IDX_W'(1);
`endif

  lcd_seq_timer #(
    .W       (CNT_W),
    .RST_VAL (CNT_RST)
  ) u_timer (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done_c   (tmr_done)
  );

  // Next state, phase-timer loads and pin values; outputs follow the next state
  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_db_d    = lcd_db_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
`ifdef LCD_INIT_SEQ_EN
    rom_idx_d   = rom_idx_q;
`else
    init_done_d = 1'b1;
`endif

    case (state_q)
      ST_PWRUP: begin
`ifdef LCD_INIT_SEQ_EN
        if (tmr_done) begin
          state_d  = ST_SETUP;
          lcd_rs_d = 1'b0;
          lcd_db_d = INIT_ROM[rom_idx_q];
          tmr_load = 1'b1;
          tmr_val  = LD_SETUP;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d  = ST_SETUP;
          lcd_rs_d = req_rs;
          lcd_db_d = req_data;
          tmr_load = 1'b1;
          tmr_val  = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_EHIGH;
          tmr_load = 1'b1;
          tmr_val  = LD_EPW;
        end
      end
      ST_EHIGH: begin
        if (tmr_done) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          state_d  = ST_WAIT;
          tmr_load = 1'b1;
          tmr_val  = is_long_wait(lcd_rs_q, lcd_db_q) ? LD_CLR : LD_CMD;
        end
      end
      ST_WAIT: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
`ifdef LCD_INIT_SEQ_EN
          // During init, chain straight into the next ROM command
          if (!init_done_q) begin
            if (rom_idx_q == INIT_IDX_W'(INIT_DEPTH - 1)) begin
              init_done_d = 1'b1;
            end else begin
              rom_idx_d = rom_idx_nxt;
              state_d   = ST_SETUP;
              lcd_rs_d  = 1'b0;
              lcd_db_d  = INIT_ROM[rom_idx_nxt];
              tmr_load  = 1'b1;
              tmr_val   = LD_SETUP;
            end
          end
`endif
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // Output decode from the next state so the pins are plain flops
  always_comb begin
    req_ready_d = (state_d == ST_IDLE) && init_done_d;
    busy_d      = (state_d != ST_IDLE) || !init_done_d;
    lcd_e_d     = (state_d == ST_EHIGH);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= ST_RESET;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_db_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_e_q     <= lcd_e_d;
      lcd_db_q    <= lcd_db_d;
    end
  end

`ifdef LCD_INIT_SEQ_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rom_idx_q <= '0;
    end else begin
      rom_idx_q <= rom_idx_d;
    end
  end
`endif

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = lcd_e_q;
  assign lcd_db    = lcd_db_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: randomized self-checking bench for lcd_cmd_sequencer.
// Expected E pulses (rs, byte, rise cycle) and ready latencies come from the
// LCD timing rules; a negedge monitor records the pulses actually seen.
// Honours LCD_INIT_SEQ_EN the same way the design does.
module tb_lcd_cmd_sequencer;

  localparam int unsigned P_PWRUP = 20;
  localparam int unsigned P_SETUP = 2;
  localparam int unsigned P_EPW   = 5;
  localparam int unsigned P_HOLD  = 2;
  localparam int unsigned P_CMD   = 10;
  localparam int unsigned P_CLR   = 30;
  localparam int unsigned BOUND   = 2000;

  logic       ACLK      = 1'b0;
  logic       ARESETN   = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs    = 1'b0;
  logic [7:0] req_data  = 8'h00;
  logic       req_ready, busy, init_done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_db;

  lcd_cmd_sequencer #(
    .T_PWRUP_CYC (P_PWRUP),
    .T_SETUP_CYC (P_SETUP),
    .T_EPW_CYC   (P_EPW),
    .T_HOLD_CYC  (P_HOLD),
    .T_CMD_CYC   (P_CMD),
    .T_CLR_CYC   (P_CLR)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .busy      (busy),
    .init_done (init_done),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_db    (lcd_db)
  );

  always #5 ACLK = ~ACLK;

  int unsigned cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  typedef struct {
    logic        rs;
    logic [7:0]  db;
    int unsigned rise;
  } exp_t;

  typedef struct {
    logic        rs;
    logic [7:0]  db_rise;
    logic        rs_fall;
    logic [7:0]  db_fall;
    int unsigned rise;
    int unsigned width;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   exp_rd = 0;
  int   obs_rd = 0;
  int   n_chk  = 0;
  int   n_err  = 0;

  // Pulse monitor: records every completed E pulse; a reset abandons the current one
  logic mon_e = 1'b0;
  obs_t mon_cur;
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      mon_e = 1'b0;
    end else begin
      if (lcd_e && !mon_e) begin
        mon_cur.rs      = lcd_rs;
        mon_cur.db_rise = lcd_db;
        mon_cur.rise    = cyc;
      end else if (!lcd_e && mon_e) begin
        mon_cur.rs_fall = lcd_rs;
        mon_cur.db_fall = lcd_db;
        mon_cur.width   = cyc - mon_cur.rise;
        obs_q.push_back(mon_cur);
      end
      mon_e = lcd_e;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
               tag, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int unsigned wait_len(input logic rs, input logic [7:0] d);
    return (!rs && d <= 8'h03) ? P_CLR : P_CMD;
  endfunction

  task automatic push_exp(input logic rs, input logic [7:0] d, input int unsigned rise);
    exp_t e;
    e.rs = rs; e.db = d; e.rise = rise;
    exp_q.push_back(e);
  endtask

  // Pair up expected and observed pulses since the last call
  task automatic verify_pulses();
    chk("pulse_count", 32'(obs_q.size() - obs_rd), 32'(exp_q.size() - exp_rd));
    while (exp_rd < exp_q.size() && obs_rd < obs_q.size()) begin
      chk("pulse_rs",      32'(obs_q[obs_rd].rs),      32'(exp_q[exp_rd].rs));
      chk("pulse_db",      32'(obs_q[obs_rd].db_rise), 32'(exp_q[exp_rd].db));
      chk("pulse_rise",    obs_q[obs_rd].rise,         exp_q[exp_rd].rise);
      chk("pulse_width",   obs_q[obs_rd].width,        P_EPW);
      chk("hold_rs",       32'(obs_q[obs_rd].rs_fall), 32'(exp_q[exp_rd].rs));
      chk("hold_db",       32'(obs_q[obs_rd].db_fall), 32'(exp_q[exp_rd].db));
      exp_rd++;
      obs_rd++;
    end
    exp_rd = exp_q.size();
    obs_rd = obs_q.size();
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy",      32'(busy),      1);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_lcd_rs",    32'(lcd_rs),    0);
    chk("rst_lcd_rw",    32'(lcd_rw),    0);
    chk("rst_lcd_e",     32'(lcd_e),     0);
    chk("rst_lcd_db",    32'(lcd_db),    0);
  endtask

  // Called on the negedge where ARESETN was just released
  task automatic after_release();
    int unsigned r, n, t;
    logic        early;
`ifdef LCD_INIT_SEQ_EN
    logic [7:0]  rom [6];
    rom = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
`endif
    r = cyc;
`ifdef LCD_INIT_SEQ_EN
    t = r + P_PWRUP;
    for (int i = 0; i < 6; i++) begin
      push_exp(1'b0, rom[i], t + P_SETUP);
      t = t + P_SETUP + P_EPW + P_HOLD + wait_len(1'b0, rom[i]);
    end
    early = 1'b0;
    n = 0;
    while (!init_done && n < BOUND) begin
      if (req_ready || !busy) early = 1'b1;
      @(negedge ACLK);
      n++;
    end
    chk("init_done_cycle", cyc - r, t - r);
    chk("ready_before_init", 32'(early), 0);
    chk("init_ready", 32'(req_ready), 1);
    chk("init_busy",  32'(busy), 0);
    verify_pulses();
`else
    @(negedge ACLK);
    chk("first_edge_cycle", cyc - r, 1);
    chk("first_edge_init_done", 32'(init_done), 1);
    chk("first_edge_ready", 32'(req_ready), 1);
    chk("first_edge_busy", 32'(busy), 0);
    early = 1'b0;
    n = 0;
    t = 0;
    repeat (20) begin
      if (lcd_e) early = 1'b1;
      @(negedge ACLK);
    end
    chk("idle_no_e", 32'(early), 0);
    verify_pulses();
`endif
  endtask

  // One request; junk valids are driven while the sequencer is not ready
  task automatic send(input logic rs, input logic [7:0] d);
    int unsigned n, acc, lat;
    n = 0;
    while (!req_ready && n < BOUND) begin
      @(negedge ACLK);
      n++;
    end
    chk("ready_before_send", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    acc = cyc;
    lat = 1 + P_SETUP + P_EPW + P_HOLD + wait_len(rs, d);
    push_exp(rs, d, acc + 1 + P_SETUP);
    @(negedge ACLK);
    req_valid = 1'b0;
    chk("accept_ready_drop", 32'(req_ready), 0);
    chk("accept_busy", 32'(busy), 1);
    chk("accept_rs", 32'(lcd_rs), 32'(rs));
    chk("accept_db", 32'(lcd_db), 32'(d));
    n = 0;
    while (!req_ready && n < BOUND) begin
      if (cyc - acc < lat) begin
        req_valid = 1'($urandom_range(0, 1));
        req_rs    = 1'($urandom_range(0, 1));
        req_data  = 8'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      @(negedge ACLK);
      n++;
    end
    req_valid = 1'b0;
    chk("ready_latency", cyc - acc, lat);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_db_held", 32'(lcd_db), 32'(d));
    chk("idle_rs_held", 32'(lcd_rs), 32'(rs));
    verify_pulses();
  endtask

  // req_valid held high across three bytes
  task automatic stream3();
    logic [7:0]  b [3];
    int unsigned n, acc, prev;
    b = '{8'h48, 8'h49, 8'h21};
    prev = 0;
    req_valid = 1'b1;
    req_rs    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_data = b[i];
      n = 0;
      while (!req_ready && n < BOUND) begin
        @(negedge ACLK);
        n++;
      end
      chk("stream_ready", 32'(req_ready), 1);
      acc = cyc;
      push_exp(1'b1, b[i], acc + 1 + P_SETUP);
      if (i > 0) chk("stream_spacing", acc - prev, 1 + P_SETUP + P_EPW + P_HOLD + P_CMD);
      prev = acc;
      @(negedge ACLK);
    end
    req_valid = 1'b0;
    n = 0;
    while (!req_ready && n < BOUND) begin
      @(negedge ACLK);
      n++;
    end
    chk("stream_final_ready", cyc - prev, 1 + P_SETUP + P_EPW + P_HOLD + P_CMD);
    verify_pulses();
  endtask

  task automatic reset_mid_pulse();
    int unsigned n;
    n = 0;
    while (!req_ready && n < BOUND) begin
      @(negedge ACLK);
      n++;
    end
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'hA5;
    @(negedge ACLK);
    req_valid = 1'b0;
    n = 0;
    while (!lcd_e && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    chk("e_high_before_reset", 32'(lcd_e), 1);
    #2 ARESETN = 1'b0;
    #1;
    chk("e_async_drop", 32'(lcd_e), 0);
    check_reset_vals();
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    after_release();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       rs;
    logic [7:0] d;
    repeat (3) @(negedge ACLK);
    check_reset_vals();
    ARESETN = 1'b1;
    after_release();

    send(1'b1, 8'h41);
    send(1'b0, 8'h01);
    send(1'b1, 8'h01);
    stream3();

    for (int i = 0; i < 12; i++) begin
      rs = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      send(rs, d);
    end

    reset_mid_pulse();
    send(1'b0, 8'h02);
    send(1'b1, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
